add_sub_pipe: RTL

- Parametrised, pipelined two's-complement adder/subtractor. Successor to the team's fixed 8-bit ripple-carry adder.
- The carry chain is split into STAGES equal slices, with one register stage per slice. Throughput is one operation per cycle.
- Adds a subtract mode, carry-in, a signed-overflow flag and a valid/ready handshake with full backpressure.
- Used wherever datapath blocks need a wide add at higher clock rates than a single ripple chain allows.

---
 rtl/add_pkg.sv | 12 +
 rtl/add_slice.sv | 22 ++
 rtl/add_sub_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared constants for the pipelined adder/subtractor and its slice adders.
// slice_width() lets instantiating modules derive and check the slice size at elaboration.
package add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SW-bit slice adder: SW+1-bit sum with carry in, carry out and carry into the MSB.
// No registers and no handshake; the enclosing pipeline owns all timing.
module add_slice #(
  parameter int SW = 1
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] s_o,
  output logic          c_o,
  output logic          c_msb_o
);

  logic [SW:0] full;

  assign full = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};
  assign s_o  = full[SW-1:0];
  assign c_o  = full[SW];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out of the XOR.
  assign c_msb_o = s_o[SW-1] ^ a_i[SW-1] ^ b_i[SW-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract, one carry slice per register stage; latency STAGES, one beat per cycle.
// Every stage advances only when the output is empty or being taken, so in_ready = !out_valid || out_ready.
module add_sub_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("add_sub_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (op_sub == OP_SUB) ? ~b : b;
  assign c0       = (op_sub == OP_ADD) ? cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SW;
    // Operand bits still waiting for a later slice once this stage has registered.
    localparam int REM = WIDTH - (k + 1) * SW;

    logic [SW-1:0]    sa;
    logic [SW-1:0]    sb;
    logic [SW-1:0]    ss;
    logic             sci;
    logic             sco;
    logic             v_d;
    logic             v_q;
    logic             c_q;
    logic [LO+SW-1:0] s_d;
    logic [LO+SW-1:0] s_q;

    if (k == 0) begin : g_in
      assign sa  = a[SW-1:0];
      assign sb  = b_eff[SW-1:0];
      assign sci = c0;
      assign v_d = in_valid;
      assign s_d = ss;
    end else begin : g_in
      assign sa  = g_stage[k-1].g_ops.a_q[SW-1:0];
      assign sb  = g_stage[k-1].g_ops.b_q[SW-1:0];
      assign sci = g_stage[k-1].c_q;
      assign v_d = g_stage[k-1].v_q;
      assign s_d = {ss, g_stage[k-1].s_q};
    end

    if (k == STAGES - 1) begin : g_slice
      logic c_msb;

      add_slice #(.SW(SW)) u_slice (
        .a_i     (sa),
        .b_i     (sb),
        .c_i     (sci),
        .s_o     (ss),
        .c_o     (sco),
        .c_msb_o (c_msb)
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb ^ sco;
        end
      end
    end else begin : g_slice
      logic c_msb_unused;

      add_slice #(.SW(SW)) u_slice (
        .a_i     (sa),
        .b_i     (sb),
        .c_i     (sci),
        .s_o     (ss),
        .c_o     (sco),
        .c_msb_o (c_msb_unused)
      );
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_src
        assign a_d = g_stage[k-1].g_ops.a_q[REM+SW-1:SW];
        assign b_d = g_stage[k-1].g_ops.b_q[REM+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= sco;
        s_q <= s_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule
